// File: rtl/vga_timing.sv
// vga_timing: 640x480 VGA pixel-timing generator.
// Two cascaded counters (h_cnt, v_cnt) run off the pixel clock. A registered
// output stage decodes them, so every output describes the same pixel and lags
// the counters by one clock.
// Optional feature: define VGA_FRAME_COUNT_EN to get an 8-bit frame counter
// that steps on each vblank_start. Otherwise frame_count is tied to zero.

module vga_timing #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] haddr,
    output logic [9:0] vaddr,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       frame_start,
    output logic       vblank_start,
    output logic [7:0] frame_count
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Both counters are 10 bits wide; reject geometries that cannot fit.
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
        $error("vga_timing: H_TOTAL and V_TOTAL must fit in 10 bits");
    end

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;

    logic hsync_d, vsync_d, display_on_d, frame_start_d, vblank_start_d;

    // Next-state for the cascaded pixel/line counters.
    always_comb begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = 10'd0;
            if (v_cnt_q == V_LAST) begin
                v_cnt_d = 10'd0;
            end else begin
                v_cnt_d = v_cnt_q + 10'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_q <= 10'd0;
            v_cnt_q <= 10'd0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Decode the current counter position into the next output values.
    always_comb begin
        hsync_d        = ~SYNC_POL;
        vsync_d        = ~SYNC_POL;
        display_on_d   = 1'b0;
        frame_start_d  = 1'b0;
        vblank_start_d = 1'b0;
        if (h_cnt_q >= HS_START && h_cnt_q < HS_END) begin
            hsync_d = SYNC_POL;
        end
        // vsync covers whole lines, independent of h_cnt.
        if (v_cnt_q >= VS_START && v_cnt_q < VS_END) begin
            vsync_d = SYNC_POL;
        end
        if (h_cnt_q < H_VIS && v_cnt_q < V_VIS) begin
            display_on_d = 1'b1;
        end
        if (h_cnt_q == 10'd0 && v_cnt_q == 10'd0) begin
            frame_start_d = 1'b1;
        end
        if (h_cnt_q == 10'd0 && v_cnt_q == V_VIS) begin
            vblank_start_d = 1'b1;
        end
    end

    // Output stage: all outputs update together and describe one pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            haddr        <= 10'd0;
            vaddr        <= 10'd0;
            hsync        <= ~SYNC_POL;
            vsync        <= ~SYNC_POL;
            display_on   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
        end else begin
            haddr        <= h_cnt_q;
            vaddr        <= v_cnt_q;
            hsync        <= hsync_d;
            vsync        <= vsync_d;
            display_on   <= display_on_d;
            frame_start  <= frame_start_d;
            vblank_start <= vblank_start_d;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] frame_count_q;

    // Step on the same edge that raises vblank_start, so the value is stable
    // across the whole visible area of the following frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_count_q <= 8'd0;
        end else if (vblank_start_d) begin
            frame_count_q <= frame_count_q + 8'd1;
        end
    end

    assign frame_count = frame_count_q;
`else
    assign frame_count = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: scoreboard bench for vga_timing using a shrunken geometry.
// The driver applies randomized reset pulses and run lengths; for every clock
// it pushes the expected outputs, computed arithmetically from the number of
// edges since reset release. A separate monitor pops and compares each cycle.

module tb_vga_timing;

    localparam int unsigned HV = 8;
    localparam int unsigned HF = 2;
    localparam int unsigned HS = 3;
    localparam int unsigned HB = 2;
    localparam int unsigned VV = 6;
    localparam int unsigned VF = 2;
    localparam int unsigned VS = 2;
    localparam int unsigned VB = 3;
    localparam int unsigned HT = HV + HF + HS + HB;
    localparam int unsigned VT = VV + VF + VS + VB;
    localparam int unsigned FR = HT * VT;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       de;
        logic       fs;
        logic       vb;
        logic [7:0] fc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] haddr, vaddr;
    logic       hsync, vsync, display_on, frame_start, vblank_start;
    logic [7:0] frame_count;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned printed = 0;
    int unsigned k = 0;  // edges since reset release; 0 while in reset
    exp_t        exp_q[$];

    vga_timing #(
        .H_VISIBLE (HV),
        .H_FRONT   (HF),
        .H_SYNC    (HS),
        .H_BACK    (HB),
        .V_VISIBLE (VV),
        .V_FRONT   (VF),
        .V_SYNC    (VS),
        .V_BACK    (VB),
        .SYNC_POL  (1'b0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .haddr        (haddr),
        .vaddr        (vaddr),
        .hsync        (hsync),
        .vsync        (vsync),
        .display_on   (display_on),
        .frame_start  (frame_start),
        .vblank_start (vblank_start),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    // Reference: pixel index (k-1) mod frame size, then plain arithmetic.
    function automatic exp_t model(input int unsigned edges);
        exp_t        e;
        int unsigned p, h, v, n;
        e = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        if (edges == 0) return e;
        p = (edges - 1) % FR;
        h = p % HT;
        v = p / HT;
        e.h  = 10'(h);
        e.v  = 10'(v);
        e.hs = (h >= HV + HF && h < HV + HF + HS) ? 1'b0 : 1'b1;
        e.vs = (v >= VV + VF && v < VV + VF + VS) ? 1'b0 : 1'b1;
        e.de = (h < HV && v < VV);
        e.fs = (h == 0 && v == 0);
        e.vb = (h == 0 && v == VV);
`ifdef VGA_FRAME_COUNT_EN
        // Number of vblank_start pulses shown so far, including this one.
        n = (edges - 1 >= VV * HT) ? ((edges - 1 - VV * HT) / FR + 1) : 0;
        e.fc = 8'(n % 256);
`else
        n = 0;
        e.fc = 8'(n);
`endif
        return e;
    endfunction

    // One clock of stimulus: advance the model, apply rst between edges,
    // then queue what the outputs must show for the rest of this cycle.
    task automatic cycle(input logic new_rst);
        @(posedge clk);
        if (!rst) k++;
        #2;
        rst = new_rst;
        if (rst) k = 0;
        exp_q.push_back(model(k));
    endtask

    task automatic run(input int unsigned n, input logic r);
        for (int unsigned i = 0; i < n; i++) cycle(r);
    endtask

    task automatic report(input string name, input int unsigned got, input int unsigned want);
        miscompares++;
        if (printed < 40) begin
            printed++;
            $display("FAIL %s vec=%0d k=%0d: got %0d, expected %0d", name, vectors, k, got, want);
        end
    endtask

    // Monitor: sample mid-cycle, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (haddr !== e.h)        report("haddr", haddr, e.h);
                if (vaddr !== e.v)        report("vaddr", vaddr, e.v);
                if (hsync !== e.hs)       report("hsync", hsync, e.hs);
                if (vsync !== e.vs)       report("vsync", vsync, e.vs);
                if (display_on !== e.de)  report("display_on", display_on, e.de);
                if (frame_start !== e.fs) report("frame_start", frame_start, e.fs);
                if (vblank_start !== e.vb) report("vblank_start", vblank_start, e.vb);
                if (frame_count !== e.fc) report("frame_count", frame_count, e.fc);
            end
        end
    end

    initial begin
        // Power-on reset held for 5 clocks, then release.
        run(5, 1'b1);
        run(2 * FR + $urandom_range(0, FR), 1'b0);

        // Reset in the middle of an hsync pulse on a visible line.
        run(3, 1'b1);
        run(1 + 2 * HT + HV + HF + 1, 1'b0);
        run(3, 1'b1);

        // Reset inside the vsync lines.
        run(1 + (VV + VF) * HT + 4, 1'b0);
        run($urandom_range(1, 4), 1'b1);

        // Randomized run lengths and reset pulse widths.
        for (int i = 0; i < 8; i++) begin
            run($urandom_range(1, 2 * FR), 1'b0);
            run($urandom_range(1, 4), 1'b1);
        end

        // Long run: 257+ vblank_start pulses to exercise frame_count wrap.
        run(258 * FR + VV * HT + 10, 1'b0);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) report("queue_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
# vga_timing

Pixel-timing generator for the 640x480 VGA output path. Runs two cascaded counters off the pixel clock and produces registered hsync/vsync, display_on and the current pixel address. Feeds the game renderer, which turns (haddr, vaddr, display_on) into colour bits packed beside hsync/vsync on the 8-bit VGA output. Also provides frame-rate event pulses so game logic can step once per frame.

## Interface
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

- clk  in  1  pixel clock (25.175 MHz nominal)
- rst  in  1  reset; asynchronous, active-high
- haddr  out  10  horizontal position, 0..H_TOTAL-1
- vaddr  out  10  vertical position, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, registered
- vsync  out  1  vertical sync, registered
- display_on  out  1  high when haddr < H_VISIBLE and vaddr < V_VISIBLE
- frame_start  out  1  one-cycle pulse when outputs show (0,0)
- vblank_start  out  1  one-cycle pulse when outputs show (0,V_VISIBLE)
- frame_count  out  8  frame counter (see Configuration)

## Operation
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525). Both must fit 10 bits.
- Internal h_cnt increments every clock; at H_TOTAL-1 wraps to 0 and v_cnt increments; v_cnt wraps V_TOTAL-1 -> 0 on the same edge as h_cnt wrap.
- Output stage registers a decode of (h_cnt, v_cnt) every clock; all outputs change on the same edge and always describe the same pixel.
- haddr/vaddr keep counting through blanking; consumers gate with display_on.
- hsync = SYNC_POL when haddr in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC) (656..751), else ~SYNC_POL.
- vsync = SYNC_POL for whole lines vaddr in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC) (490..491), all haddr, else ~SYNC_POL.
- frame_start high iff outputs show haddr=0, vaddr=0; vblank_start high iff haddr=0, vaddr=V_VISIBLE.

## Timing
- Reset (async assert): h_cnt=v_cnt=0; haddr=0, vaddr=0, hsync=vsync=~SYNC_POL, display_on=0, frame_start=0, vblank_start=0, frame_count=0.
- Outputs lag counters by one cycle. First clk edge after rst release: outputs show (0,0), display_on=1, frame_start=1; h_cnt becomes 1.
- Pixel (h,v) of every frame appears exactly 1 + v*H_TOTAL + h edges after rst release, modulo H_TOTAL*V_TOTAL (420000).
- frame_start period 420000 clocks; vblank_start period 420000 clocks, 384000 clocks after frame_start.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous); sequence restarts at (0,0) on first edge after release; no partial sync pulse is stretched beyond reset assertion.
- No handshake; outputs are free-running and never stall.

## Configuration
- VGA_FRAME_COUNT_EN defined: frame_count is an 8-bit register, increments on the edge that asserts vblank_start (stable throughout the visible area), wraps 255 -> 0, reset 0.
- Not defined: frame_count tied to 8'd0, no register inferred; all other behaviour identical.

## Test plan
- Hold rst high 5 clocks -> haddr=0, vaddr=0, hsync=vsync=1, display_on=0, frame_start=0, frame_count=0.
- Release rst -> first edge: haddr=0, vaddr=0, display_on=1, frame_start=1; next edge haddr=1, frame_start=0; haddr=639 display_on=1, haddr=640 display_on=0.
- Line 0: hsync low for exactly 96 clocks, haddr 656..751; line wraps 799 -> 0 with vaddr 0 -> 1.
- Frame: vsync low exactly 1600 clocks (vaddr 490..491); display_on=0 for all vaddr>=480; consecutive frame_start 420000 clocks apart; vblank_start at (0,480).
- Assert rst at (300,200) for 3 clocks -> outputs reset asynchronously; after release sequence restarts at (0,0) with frame_start=1.
- VGA_FRAME_COUNT_EN on: run 257 frames -> frame_count 1..255, 0, 1 at successive vblank_starts; macro off -> frame_count=0 throughout.
